msx_bus_event_fifo: RTL and testbench

- Upstream capture stage for the MSX-to-Pi bridge.
- Watches the asynchronous MSX cartridge bus and records each qualified memory or I/O access as one event: address, data and type.
- Buffers events in a first-word-fall-through FIFO. The Pi-side command logic drains it at its own pace, so no MSX cycle is lost while the Pi is busy.

---
 rtl/msx_bus_event_fifo_if.sv | 27 ++
 rtl/msx_bus_event_fifo.sv | 118 +++++++++++
 tb/tb_msx_bus_event_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/msx_bus_event_fifo_if.sv
// MSX cartridge bus plus the Pi-side event port of the capture FIFO.
// The slave modport is the capture block; the master modport is whoever drives the bus and drains events.
interface msx_bus_event_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [15:0]         a;
  logic [7:0]          d;
  logic                rd, wr, mreq, iorq, sltsl, m1;
  logic                ev_valid;
  logic [15:0]         ev_addr;
  logic [7:0]          ev_data;
  logic [3:0]          ev_flags;
  logic                ev_pop;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                clr_overflow;

  modport slave (
    input  a, d, rd, wr, mreq, iorq, sltsl, m1, ev_pop, clr_overflow,
    output ev_valid, ev_addr, ev_data, ev_flags, count, overflow
  );

  modport master (
    output a, d, rd, wr, mreq, iorq, sltsl, m1, ev_pop, clr_overflow,
    input  ev_valid, ev_addr, ev_data, ev_flags, count, overflow
  );
endinterface

// File: rtl/msx_bus_event_fifo.sv
// Captures each qualified MSX memory/IO access as one event and queues it in a
// first-word-fall-through FIFO for the Pi-side command logic.
module msx_bus_event_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  msx_bus_event_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int SW    = $clog2(SYNC_STAGES + 2);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  flags;
  } ev_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_END} state_t;

  // Strobe order within each stage: {m1, sltsl, iorq, mreq, wr, rd}
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic rd_s, wr_s, mreq_s, iorq_s, sltsl_s, m1_s;
  logic mem_hit, io_hit, act;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          lost_q, lost_d;

  ev_t  mem_q [DEPTH];
  ev_t  entry, head;
  logic full, empty, pop_ok, push_req, push_ok, drop;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {bus.m1, bus.sltsl, bus.iorq, bus.mreq, bus.wr, bus.rd};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign {m1_s, sltsl_s, iorq_s, mreq_s, wr_s, rd_s} = sync_q[SYNC_STAGES-1];

  assign mem_hit = !mreq_s & !sltsl_s;
  assign io_hit  = !iorq_s & m1_s;
  assign act     = (!rd_s | !wr_s) & (mem_hit | io_hit);

  // After reset the synchronisers still read "deasserted" for a few cycles;
  // a strobe that shows up inside that window was already low at reset release,
  // so it is parked in WAIT_END instead of being captured.
  always_comb begin
    state_d  = state_q;
    settle_d = (settle_q != '0) ? settle_q - SW'(1) : settle_q;
    case (state_q)
      IDLE:     if (act) state_d = (settle_q != '0) ? WAIT_END : CAPTURE;
      CAPTURE:  state_d = WAIT_END;
      WAIT_END: if (rd_s & wr_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                    (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_ok   = bus.ev_pop & !empty;
  assign push_req = (state_q == CAPTURE);
  assign push_ok  = push_req & (!full | pop_ok);
  assign drop     = push_req & full & !pop_ok;

  always_comb begin
    entry.addr  = bus.a;
    entry.data  = bus.d;
    entry.flags = {!wr_s, io_hit, !m1_s & mem_hit, lost_q};
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // A drop in the same cycle as a clear keeps the flag set
    overflow_d = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
    lost_d     = drop ? 1'b1 : (push_ok ? 1'b0 : lost_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      state_q    <= IDLE;
      settle_q   <= SW'(SYNC_STAGES + 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      settle_q   <= settle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= entry;
  end

  assign head         = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign bus.ev_valid = !empty;
  assign bus.ev_addr  = empty ? '0 : head.addr;
  assign bus.ev_data  = empty ? '0 : head.data;
  assign bus.ev_flags = empty ? '0 : head.flags;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_msx_bus_event_fifo.sv
// Directed bench for msx_bus_event_fifo: bus cycles of each type, overflow,
// full push+pop, clear/drop collision and reset in the middle of a cycle.
module tb_msx_bus_event_fifo;
  localparam int DL = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  msx_bus_event_fifo_if #(.DEPTH_LOG2(DL)) bus ();

  msx_bus_event_fifo #(.DEPTH_LOG2(DL), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.a = '0; bus.d = '0;
    bus.rd = 1'b1; bus.wr = 1'b1; bus.mreq = 1'b1; bus.iorq = 1'b1;
    bus.sltsl = 1'b1; bus.m1 = 1'b1;
  endtask

  // Address phase one clock ahead, then the rd/wr strobe falls at a negedge
  task automatic bus_start(input logic [15:0] addr, input logic [7:0] data, input bit is_wr,
                           input bit is_io, input bit m1_low, input bit slot_hi);
    @(negedge clk);
    bus.a = addr; bus.d = data; bus.m1 = !m1_low; bus.sltsl = slot_hi;
    if (is_io) bus.iorq = 1'b0; else bus.mreq = 1'b0;
    @(negedge clk);
    if (is_wr) bus.wr = 1'b0; else bus.rd = 1'b0;
  endtask

  task automatic bus_end();
    repeat (8) @(negedge clk);
    bus.rd = 1'b1; bus.wr = 1'b1;
    @(negedge clk);
    bus_idle();
    repeat (SS + 3) @(negedge clk);
  endtask

  // cap_pop / cap_clr are driven during the CAPTURE cycle so they meet the push
  task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] data, input bit is_wr,
                           input bit is_io, input bit m1_low, input bit slot_hi,
                           input bit cap_pop, input bit cap_clr);
    bus_start(addr, data, is_wr, is_io, m1_low, slot_hi);
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    bus.ev_pop = cap_pop; bus.clr_overflow = cap_clr;
    @(negedge clk);
    bus.ev_pop = 1'b0; bus.clr_overflow = 1'b0;
    bus_end();
  endtask

  task automatic mwrite(input logic [15:0] addr, input logic [7:0] data);
    bus_cycle(addr, data, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    @(negedge clk); bus.ev_pop = 1'b1;
    @(negedge clk); bus.ev_pop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.clr_overflow = 1'b1;
    @(negedge clk); bus.clr_overflow = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_idle();
    bus.ev_pop = 1'b0; bus.clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (SS + 3) @(negedge clk);
    chk("rst_valid", 32'(bus.ev_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_addr",  32'(bus.ev_addr), 32'd0);

    // Memory write with latency check: valid appears SS+2 clocks after wr falls
    bus_start(16'h4000, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (SS + 1) @(posedge clk);
    #1 chk("lat_early", 32'(bus.ev_valid), 32'd0);
    @(posedge clk);
    #1 chk("lat_valid", 32'(bus.ev_valid), 32'd1);
    bus_end();
    chk("mw_addr",  32'(bus.ev_addr), 32'h4000);
    chk("mw_data",  32'(bus.ev_data), 32'h5A);
    chk("mw_flags", 32'(bus.ev_flags), 32'b1000);
    chk("mw_count", 32'(bus.count), 32'd1);
    pop1();
    chk("mw_popped", 32'(bus.count), 32'd0);

    // I/O read
    bus_cycle(16'h0098, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("io_count", 32'(bus.count), 32'd1);
    chk("io_addr",  32'(bus.ev_addr), 32'h0098);
    chk("io_data",  32'(bus.ev_data), 32'h33);
    chk("io_flags", 32'(bus.ev_flags), 32'b0100);
    pop1();

    // Interrupt acknowledge and foreign slot produce nothing
    bus_cycle(16'h00FF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("inta_count", 32'(bus.count), 32'd0);
    bus_cycle(16'h4000, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("slot_count", 32'(bus.count), 32'd0);

    // Opcode fetch
    bus_cycle(16'h8000, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("m1_count", 32'(bus.count), 32'd1);
    chk("m1_addr",  32'(bus.ev_addr), 32'h8000);
    chk("m1_flags", 32'(bus.ev_flags), 32'b0010);
    pop1();

    // 18 writes into a 16-deep FIFO: last two dropped
    for (int i = 0; i < 18; i++) mwrite(16'(16'h1000 + i), 8'(i));
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_addr", 32'(bus.ev_addr), 32'(16'h1000 + i));
      pop1();
    end
    chk("ovf_empty", 32'(bus.count), 32'd0);
    mwrite(16'h2000, 8'hA0);
    chk("lost_set", 32'(bus.ev_flags), 32'b1001);
    pop1();
    mwrite(16'h2001, 8'hA1);
    chk("lost_clr", 32'(bus.ev_flags), 32'b1000);
    pop1();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    pulse_clr();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full FIFO: push together with pop is accepted
    for (int i = 0; i < 16; i++) mwrite(16'(16'h3000 + i), 8'(i));
    chk("full_count", 32'(bus.count), 32'd16);
    bus_cycle(16'h3100, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pp_count", 32'(bus.count), 32'd16);
    chk("pp_ovf",   32'(bus.overflow), 32'd0);
    chk("pp_head",  32'(bus.ev_addr), 32'h3001);
    repeat (15) pop1();
    chk("pp_tail_addr",  32'(bus.ev_addr), 32'h3100);
    chk("pp_tail_data",  32'(bus.ev_data), 32'h99);
    chk("pp_tail_flags", 32'(bus.ev_flags), 32'b1000);
    pop1();
    pop1();
    chk("epop_count", 32'(bus.count), 32'd0);
    chk("epop_valid", 32'(bus.ev_valid), 32'd0);
    chk("epop_addr",  32'(bus.ev_addr), 32'd0);
    chk("epop_data",  32'(bus.ev_data), 32'd0);
    chk("epop_flags", 32'(bus.ev_flags), 32'd0);

    // Clear coinciding with a drop: set wins
    for (int i = 0; i < 16; i++) mwrite(16'(16'h6000 + i), 8'(i));
    chk("clr_pre_ovf", 32'(bus.overflow), 32'd0);
    bus_cycle(16'h6100, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_ovf",   32'(bus.overflow), 32'd1);
    chk("clr_drop_count", 32'(bus.count), 32'd16);

    // Reset while wr is held low mid-cycle
    bus_start(16'h5000, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_valid", 32'(bus.ev_valid), 32'd0);
    chk("mrst_count", 32'(bus.count), 32'd0);
    chk("mrst_ovf",   32'(bus.overflow), 32'd0);
    chk("mrst_addr",  32'(bus.ev_addr), 32'd0);
    chk("mrst_flags", 32'(bus.ev_flags), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mrst_held_count", 32'(bus.count), 32'd0);
    bus_end();
    chk("mrst_end_count", 32'(bus.count), 32'd0);
    mwrite(16'h5001, 8'h22);
    chk("mrst_new_count", 32'(bus.count), 32'd1);
    chk("mrst_new_addr",  32'(bus.ev_addr), 32'h5001);
    chk("mrst_new_flags", 32'(bus.ev_flags), 32'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
